// File: rtl/sap_pkg.sv
// sap_pkg: shared opcodes, control-bit indices and sequencer state encoding
// Used by sap_microcode_rom and sap_control_sequencer.
package sap_pkg;
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int unsigned CTRL_HLT = 15;
   localparam int unsigned CTRL_MI  = 14;
   localparam int unsigned CTRL_RI  = 13;
   localparam int unsigned CTRL_RO  = 12;
   localparam int unsigned CTRL_IO  = 11;
   localparam int unsigned CTRL_II  = 10;
   localparam int unsigned CTRL_AI  = 9;
   localparam int unsigned CTRL_AO  = 8;
   localparam int unsigned CTRL_EO  = 7;
   localparam int unsigned CTRL_SU  = 6;
   localparam int unsigned CTRL_BI  = 5;
   localparam int unsigned CTRL_OI  = 4;
   localparam int unsigned CTRL_CE  = 3;
   localparam int unsigned CTRL_CO  = 2;
   localparam int unsigned CTRL_J   = 1;
   localparam int unsigned CTRL_FI  = 0;

   typedef enum logic [2:0] {
      T0   = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      T4   = 3'd4,
      HALT = 3'd5
   } state_t;

   function automatic logic [15:0] cb(input int unsigned i);
      return 16'h1 << i;
   endfunction
endpackage

// File: rtl/sap_microcode_rom.sv
// sap_microcode_rom: combinational decode of (state, opcode, flags) -> control word
// Ports: state_i step, opcode_i IR nibble, carry_i/zero_i flags,
//        ctrl_o control word, last_o high on an instruction's final step.
// Macro SAP_JUMP_EN enables JMP/JC/JZ; otherwise they decode as NOP.
module sap_microcode_rom
   import sap_pkg::*;
(
   input  state_t      state_i,
   input  logic [3:0]  opcode_i,
   input  logic        carry_i,
   input  logic        zero_i,
   output logic [15:0] ctrl_o,
   output logic        last_o
);
`ifndef SAP_JUMP_EN
   logic unused_flags;
   assign unused_flags = carry_i ^ zero_i;
`endif
   always_comb begin
      ctrl_o = '0;
      last_o = 1'b1;
      case (state_i)
         T0: begin
            ctrl_o = cb(CTRL_CO) | cb(CTRL_MI);
            last_o = 1'b0;
         end
         T1: begin
            ctrl_o = cb(CTRL_RO) | cb(CTRL_II) | cb(CTRL_CE);
            last_o = 1'b0;
         end
         T2: case (opcode_i)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
               ctrl_o = cb(CTRL_IO) | cb(CTRL_MI);
               last_o = 1'b0;
            end
            OP_LDI: ctrl_o = cb(CTRL_IO) | cb(CTRL_AI);
`ifdef SAP_JUMP_EN
            OP_JMP: ctrl_o = cb(CTRL_IO) | cb(CTRL_J);
            OP_JC:  ctrl_o = carry_i ? (cb(CTRL_IO) | cb(CTRL_J)) : '0;
            OP_JZ:  ctrl_o = zero_i ? (cb(CTRL_IO) | cb(CTRL_J)) : '0;
`endif
            OP_OUT: ctrl_o = cb(CTRL_AO) | cb(CTRL_OI);
            OP_HLT: ctrl_o = cb(CTRL_HLT);
            default: ctrl_o = '0;
         endcase
         T3: case (opcode_i)
            OP_LDA: ctrl_o = cb(CTRL_RO) | cb(CTRL_AI);
            OP_STA: ctrl_o = cb(CTRL_AO) | cb(CTRL_RI);
            OP_ADD, OP_SUB: begin
               ctrl_o = cb(CTRL_RO) | cb(CTRL_BI);
               last_o = 1'b0;
            end
            default: ctrl_o = '0;
         endcase
         T4: ctrl_o = cb(CTRL_EO) | cb(CTRL_AI) | cb(CTRL_FI) | ((opcode_i == OP_SUB) ? cb(CTRL_SU) : '0);
         HALT: begin
            ctrl_o = cb(CTRL_HLT);
            last_o = 1'b0;
         end
         default: ctrl_o = '0;
      endcase
   end
endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: T-state sequencer for the SAP CPU control unit
// Ports: clk, rst_n (async active-low), en step enable, opcode IR nibble,
//        carry/zero flags, ctrl control word, t_state current step (5=HALT), halted.
// Macro SAP_JUMP_EN (via sap_microcode_rom) enables JMP/JC/JZ.
module sap_control_sequencer
   import sap_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [3:0]  opcode,
   input  logic        carry,
   input  logic        zero,
   output logic [15:0] ctrl,
   output logic [2:0]  t_state,
   output logic        halted
);
   state_t state_q, state_d;
   logic   last;

   sap_microcode_rom u_rom (
      .state_i  (state_q),
      .opcode_i (opcode),
      .carry_i  (carry),
      .zero_i   (zero),
      .ctrl_o   (ctrl),
      .last_o   (last)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= T0;
      else        state_q <= state_d;

   // HALT is absorbing; only reset leaves it.
   always_comb begin
      state_d = state_q;
      if (en && state_q != HALT)
         state_d = (state_q == T2 && opcode == OP_HLT) ? HALT :
                   last ? T0 : state_t'(state_q + 3'd1);
   end

   assign t_state = state_q;
   assign halted  = (state_q == HALT);
endmodule
